// File: rtl/log2lin_interp_pipe.sv
// rtl/log2lin_interp_pipe.sv - pipelined log-to-linear converter with table interpolation
module log2lin_interp_pipe #(
    parameter int INT_W  = 7,
    parameter int FRAC_W = 6,
    parameter int DATA_W = 9,
    parameter int CH_W   = 5,
    parameter int STEP   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [INT_W+FRAC_W-1:0]  in_addr,
    input  logic [INT_W+FRAC_W-1:0]  in_att,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     in_twos,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W:0]          out_data,
    output logic [CH_W-1:0]          out_ch
);
    localparam int A_W   = INT_W + FRAC_W;
    localparam int DEPTH = 1 << INT_W;
    localparam int Q     = 62;
    localparam int PW    = FRAC_W + DATA_W + 2;

    // Q62 fixed-point helpers used only at elaboration to build the exponential table.
    function automatic logic [63:0] qmul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p >> Q);
    endfunction

    // Bisection for r = 2^(-1/STEP): largest r whose STEP-th power does not exceed one half.
    function automatic logic [63:0] root_half();
        logic [63:0] lo, hi, mid, pw;
        lo = 64'd1 << (Q - 1);
        hi = 64'd1 << Q;
        for (int it = 0; it < Q; it++) begin
            mid = (lo + hi) >> 1;
            pw  = 64'd1 << Q;
            for (int j = 0; j < STEP; j++) pw = qmul(pw, mid);
            if (pw <= (64'd1 << (Q - 1))) lo = mid;
            else                          hi = mid;
        end
        return lo;
    endfunction

    // Whole octaves are applied as exact shifts so entries such as k=STEP round exactly.
    function automatic logic [DEPTH*DATA_W-1:0] build_rom();
        logic [DEPTH*DATA_W-1:0] rom;
        logic [63:0]             r, f;
        int                      sh;
        rom = '0;
        r   = root_half();
        for (int k = 0; k < DEPTH - 1; k++) begin
            f = 64'd1 << Q;
            for (int j = 0; j < k % STEP; j++) f = qmul(f, r);
            sh = Q + k / STEP;
            rom[k*DATA_W +: DATA_W] = DATA_W'((128'((1 << DATA_W) - 1) * {64'd0, f}
                                               + (128'd1 << (sh - 1))) >> sh);
        end
        return rom;
    endfunction

    localparam logic [DEPTH*DATA_W-1:0] ROM = build_rom();

    logic [DATA_W-1:0] rom_mem [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_mem[g] = ROM[g*DATA_W +: DATA_W];
    end

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic              s1_valid, s2_valid, s3_valid;
    logic              s1_sign, s2_sign, s3_sign;
    logic              s1_twos, s2_twos, s3_twos;
    logic [CH_W-1:0]   s1_ch, s2_ch, s3_ch;
    logic [A_W-1:0]    s1_a;
    logic [DATA_W-1:0] s2_d0, s2_d1, s3_m;
    logic [FRAC_W-1:0] s2_w;

    logic [A_W:0]              sum;
    logic [A_W-1:0]            a_sat;
    logic [INT_W-1:0]          idx, idx1;
    logic signed [DATA_W:0]    diff;
    logic signed [PW-1:0]      prod;
    logic [DATA_W-1:0]         m_next;
    logic [DATA_W:0]           mext, fmt;

    always_comb begin
        sum   = {1'b0, in_addr} + {1'b0, in_att};
        a_sat = sum[A_W] ? '1 : sum[A_W-1:0];
        idx   = s1_a[A_W-1:FRAC_W];
        idx1  = (&idx) ? idx : idx + INT_W'(1);
    end

    // Interpolation: diff is never positive, so the floor shift pulls m down from d0 toward d1.
    always_comb begin
        diff   = $signed({1'b0, s2_d1}) - $signed({1'b0, s2_d0});
        prod   = PW'($signed({1'b0, s2_w})) * PW'(diff);
        m_next = DATA_W'(PW'($signed({1'b0, s2_d0})) + (prod >>> FRAC_W));
    end

    always_comb begin
        mext = {1'b0, s3_m};
        if (s3_twos) fmt = s3_sign ? (~mext + 1'b1) : mext;
        else         fmt = {s3_sign, s3_m};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            out_data  <= fmt;
            out_ch    <= s3_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= in_sign;
            s1_twos <= in_twos;
            s1_ch   <= in_ch;
            s1_a    <= a_sat;
            s2_d0   <= rom_mem[idx];
            s2_d1   <= rom_mem[idx1];
            s2_w    <= s1_a[FRAC_W-1:0];
            s2_sign <= s1_sign;
            s2_twos <= s1_twos;
            s2_ch   <= s1_ch;
            s3_m    <= m_next;
            s3_sign <= s2_sign;
            s3_twos <= s2_twos;
            s3_ch   <= s2_ch;
        end
    end
endmodule

// File: tb/tb_log2lin_interp_pipe.sv
// tb/tb_log2lin_interp_pipe.sv - self-checking bench for log2lin_interp_pipe
module tb_log2lin_interp_pipe;
    localparam int IW = 7, FW = 6, DW = 9, CW = 5, ST = 16;
    localparam int AW = IW + FW;

    logic          clk = 0, reset = 0;
    logic          in_valid = 0, in_ready, in_sign = 0, in_twos = 0;
    logic [AW-1:0] in_addr = '0, in_att = '0;
    logic [CW-1:0] in_ch = '0;
    logic          out_valid, out_ready = 1;
    logic [DW:0]   out_data;
    logic [CW-1:0] out_ch;

    log2lin_interp_pipe #(.INT_W(IW), .FRAC_W(FW), .DATA_W(DW), .CH_W(CW), .STEP(ST)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_addr(in_addr), .in_att(in_att), .in_ch(in_ch),
        .in_twos(in_twos), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int ch; int lit; bit has_lit; } exp_t;
    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0;
    int   cur_lit = 0;
    bit   cur_has_lit = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    function automatic int tbl(input int k);
        if (k == (1 << IW) - 1) return 0;
        return $rtoi(real'((1 << DW) - 1) * (2.0 ** (-real'(k) / real'(ST))) + 0.5);
    endfunction

    function automatic int model(input bit s, input int addr, input int att, input bit tw);
        int a, i, w, d0, d1, num, q, m;
        a = addr + att;
        if (a > (1 << AW) - 1) a = (1 << AW) - 1;
        i  = a / (1 << FW);
        w  = a % (1 << FW);
        d0 = tbl(i);
        d1 = (i == (1 << IW) - 1) ? d0 : tbl(i + 1);
        num = w * (d1 - d0);
        q = num / (1 << FW);
        if (q * (1 << FW) > num) q = q - 1;
        m = d0 + q;
        if (tw) return s ? ((1 << (DW + 1)) - m) % (1 << (DW + 1)) : m;
        return (int'(s) << DW) | m;
    endfunction

    // Scoreboard: transfers are judged at the falling edge, just before the edge that performs them.
    initial begin
        bit   held = 0;
        int   held_data = 0, held_ch = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                held = 0;
            end else begin
                if (held) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_data", int'(out_data), held_data);
                    chk("stall_ch", int'(out_ch), held_ch);
                end
                held      = out_valid && !out_ready;
                held_data = int'(out_data);
                held_ch   = int'(out_ch);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_ch", int'(out_ch), e.ch);
                        if (e.has_lit) chk("lit_data", int'(out_data), e.lit);
                    end
                end
                if (in_valid && in_ready) begin
                    e.data    = model(in_sign, int'(in_addr), int'(in_att), in_twos);
                    e.ch      = int'(in_ch);
                    e.lit     = cur_lit;
                    e.has_lit = cur_has_lit;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic set_in(input bit s, input int addr, input int att, input bit tw,
                          input int ch, input int lit, input bit has_lit);
        in_valid = 1; in_sign = s; in_addr = AW'(addr); in_att = AW'(att);
        in_twos = tw; in_ch = CW'(ch); cur_lit = lit; cur_has_lit = has_lit;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0; cur_has_lit = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct { bit s; int addr; int att; bit tw; int lit; } vec_t;
    vec_t dv[11];

    initial begin
        int n;
        dv[0]  = '{0, 32, 0, 1, 500};
        dv[1]  = '{0, 1, 0, 1, 510};
        dv[2]  = '{0, 16*64, 0, 1, 256};
        dv[3]  = '{0, 126*64+32, 0, 1, 1};
        dv[4]  = '{0, 127*64+63, 0, 1, 0};
        dv[5]  = '{1, 0, 0, 1, 'h201};
        dv[6]  = '{1, 0, 0, 0, 'h3FF};
        dv[7]  = '{1, 127*64, 0, 1, 0};
        dv[8]  = '{0, 'h1F80, 'h100, 1, 0};
        dv[9]  = '{0, 64, 15*64, 1, 256};
        dv[10] = '{1, 'h1F80, 'h100, 0, 'h200};

        chk("tbl_0", tbl(0), 511);
        chk("tbl_1", tbl(1), 489);
        chk("tbl_16", tbl(16), 256);
        chk("tbl_126", tbl(126), 2);
        chk("tbl_127", tbl(127), 0);
        foreach (dv[i]) chk($sformatf("model_pin%0d", i), model(dv[i].s, dv[i].addr, dv[i].att, dv[i].tw), dv[i].lit);

        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        set_in(0, 0, 0, 1, 3, 511, 1);
        wait_accept();
        in_valid = 0; cur_has_lit = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("latency_valid%0d", c), int'(out_valid), (c == 3) ? 1 : 0);
        end
        chk("latency_data", int'(out_data), 511);
        chk("latency_ch", int'(out_ch), 3);
        @(posedge clk); #1;

        foreach (dv[i]) begin
            set_in(dv[i].s, dv[i].addr, dv[i].att, dv[i].tw, i + 1, dv[i].lit, 1);
            wait_accept();
        end
        idle(8);

        for (int c = 0; c < 5; c++) begin
            set_in(c[0], $urandom_range(0, 8191), 0, c[1], c, 0, 0);
            wait_accept();
        end
        set_in(1, 100, 50, 0, 5, 0, 0);
        out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
        wait_accept();
        idle(8);
        chk("bp_drained", exp_q.size(), 0);

        for (int c = 0; c < 3; c++) begin
            set_in(0, c * 64, 0, 1, 20 + c, 0, 0);
            wait_accept();
        end
        in_valid = 0;
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midrst_no_stale", int'(out_valid), 0);
        end
        @(posedge clk); #1;

        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sign   = $urandom_range(0, 1) != 0;
            in_twos   = $urandom_range(0, 1) != 0;
            in_ch     = CW'($urandom);
            in_addr   = AW'($urandom);
            case ($urandom_range(0, 3))
                0:       in_att = '0;
                1:       in_att = AW'($urandom_range(0, 255));
                default: in_att = AW'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 0;
        out_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("final_drained", exp_q.size(), 0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
